// File: rtl/bus_cycle_bridge_pkg.sv
// ---------------------------------------------------------------------------
// bus_bridge_pkg
// Shared types and constants for the CPU-to-AXI bus cycle bridge.
//   state_t          : bridge sequencer states
//   AXI_ADDR32_*     : AXI byte addresses of the DRAM window and UART registers
//   UART_PORT_*      : CPU IO port numbers that are forwarded to the UART
//   laneStrobe()     : one-hot write strobe for a byte lane
//   laneByte()       : extract the byte of a 32-bit word selected by a lane
// ---------------------------------------------------------------------------
package bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // System address map; the DRAM base leaves bits [27:0] free for the
    // bank/offset concatenation.
    localparam logic [31:0] AXI_ADDR32_DRAM_BASE = 32'h4000_0000;
    localparam logic [31:0] AXI_ADDR32_UART_RX   = 32'h1000_0000;
    localparam logic [31:0] AXI_ADDR32_UART_TX   = 32'h1000_0004;
    localparam logic [31:0] AXI_ADDR32_UART_STAT = 32'h1000_0008;

    localparam logic [7:0] UART_PORT_RX   = 8'h00;
    localparam logic [7:0] UART_PORT_TX   = 8'h01;
    localparam logic [7:0] UART_PORT_STAT = 8'h02;

    function automatic logic [3:0] laneStrobe(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bus_cycle_bridge_if.sv
// ---------------------------------------------------------------------------
// bus_cycle_bridge_if
// Bundles the CPU strobe bus and the AXI request/response port of the bridge.
//   CPU side : IO, MEM, RD, WR, A, D (in)   cpu_ready, cpu_rdata (out)
//   AXI side : req_valid, req_addr, req_wdata, req_wstrb, req_is_read (out)
//              req_ready, resp_valid, resp_rdata, resp_err (in)
//   Status   : err_flag (out)
// modport master : the bridge itself (it masters the AXI request port)
// modport slave  : the surroundings, i.e. CPU pins plus the AXI master shim
// ---------------------------------------------------------------------------
interface bus_cycle_bridge_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  IO;
    logic                  MEM;
    logic                  RD;
    logic                  WR;
    logic [ADDR_WIDTH-1:0] A;
    logic [7:0]            D;
    logic                  cpu_ready;
    logic [7:0]            cpu_rdata;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;
    logic                  req_is_read;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  err_flag;

    modport master (
        input  IO, MEM, RD, WR, A, D, req_ready, resp_valid, resp_rdata, resp_err,
        output cpu_ready, cpu_rdata, req_valid, req_addr, req_wdata, req_wstrb,
               req_is_read, err_flag
    );

    modport slave (
        output IO, MEM, RD, WR, A, D, req_ready, resp_valid, resp_rdata, resp_err,
        input  cpu_ready, cpu_rdata, req_valid, req_addr, req_wdata, req_wstrb,
               req_is_read, err_flag
    );
endinterface

// File: rtl/bus_cycle_bridge_bank_window_map.sv
// ---------------------------------------------------------------------------
// bank_window_map
// Holds the bank registers that map each CPU memory window onto DRAM and
// translates a CPU memory address into a 32-bit AXI byte address.
//   clk, rst    : clock, asynchronous active-high reset (banks -> identity)
//   i_we        : write the bank register selected by i_idx with i_wdata
//   i_idx       : bank register index for both the write and read port
//   i_wdata     : new bank value
//   o_rdata     : bank register selected by i_idx
//   i_memAddr   : CPU address of a memory cycle
//   o_axiAddr   : DRAM base | {bank[window], offset}
// ---------------------------------------------------------------------------
module bank_window_map
    import bus_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int NUM_WINDOWS = 4,
    parameter int BANK_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_we,
    input  logic [$clog2(NUM_WINDOWS)-1:0] i_idx,
    input  logic [BANK_W-1:0]              i_wdata,
    output logic [BANK_W-1:0]              o_rdata,
    input  logic [ADDR_WIDTH-1:0]          i_memAddr,
    output logic [31:0]                    o_axiAddr
);
    localparam int WIN_W = $clog2(NUM_WINDOWS);
    localparam int OFF_W = ADDR_WIDTH - WIN_W;

    logic [BANK_W-1:0] r_bank [NUM_WINDOWS];
    logic [WIN_W-1:0]  w_win;

    // Bank registers come out of reset as an identity map so software that
    // never touches them sees a flat window layout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                r_bank[i] <= BANK_W'(i);
            end
        end else if (i_we) begin
            r_bank[i_idx] <= i_wdata;
        end
    end

    assign w_win     = i_memAddr[ADDR_WIDTH-1 -: WIN_W];
    assign o_rdata   = r_bank[i_idx];
    assign o_axiAddr = AXI_ADDR32_DRAM_BASE | 32'({r_bank[w_win], i_memAddr[OFF_W-1:0]});

endmodule

// File: rtl/bus_cycle_bridge.sv
// ---------------------------------------------------------------------------
// bus_cycle_bridge
// Sequences one CPU bus cycle (IO/MEM x RD/WR) into at most one AXI
// request/response, holding the CPU in wait states until the cycle is done.
// Bank registers at IO ports BANK_IO_BASE+i are served locally; UART ports
// and memory go to AXI; any other IO port flags an error.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bus_cycle_bridge_if.master (CPU strobes, AXI port, err_flag)
// ---------------------------------------------------------------------------
module bus_cycle_bridge
    import bus_bridge_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 20,
    parameter int         NUM_WINDOWS    = 4,
    parameter int         BANK_W         = 8,
    parameter logic [7:0] BANK_IO_BASE   = 8'h90,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    bus_cycle_bridge_if.master bus
);
    localparam int         WIN_W       = $clog2(NUM_WINDOWS);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_CYCLES);

    state_t            r_state;
    state_t            w_nextState;
    logic [31:0]       r_reqAddr;
    logic [31:0]       r_reqWdata;
    logic [3:0]        r_reqWstrb;
    logic              r_reqIsRead;
    logic [1:0]        r_lane;
    logic [7:0]        r_cpuRdata;
    logic              r_errFlag;
    logic [7:0]        r_cnt;

    logic              w_legal;
    logic [7:0]        w_port;
    logic [7:0]        w_bankOff;
    logic              w_bankHit;
    logic [WIN_W-1:0]  w_bankIdx;
    logic              w_bankWe;
    logic [BANK_W-1:0] w_bankWdata;
    logic [BANK_W-1:0] w_bankRdata;
    logic [31:0]       w_memAddr;
    logic              w_uartHit;
    logic [31:0]       w_uartAddr;
    logic              w_goReq;
    logic [1:0]        w_lane;

    assign w_legal     = (bus.IO ^ bus.MEM) && (bus.RD ^ bus.WR);
    assign w_port      = bus.A[7:0];
    // Subtraction wraps for ports below the base, so the range check needs both bounds.
    assign w_bankOff   = w_port - BANK_IO_BASE;
    assign w_bankHit   = bus.IO && (w_port >= BANK_IO_BASE) && ({1'b0, w_bankOff} < 9'(NUM_WINDOWS));
    assign w_bankIdx   = w_bankOff[WIN_W-1:0];
    assign w_bankWdata = BANK_W'(bus.D);
    assign w_bankWe    = (r_state == IDLE) && w_legal && w_bankHit && bus.WR;
    assign w_goReq     = bus.MEM || (!w_bankHit && w_uartHit);
    // UART TX is a byte register at lane 0 of its word, independent of the CPU address.
    assign w_lane      = (bus.IO && bus.WR) ? AXI_ADDR32_UART_TX[1:0] : bus.A[1:0];

    bank_window_map #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_WINDOWS (NUM_WINDOWS),
        .BANK_W      (BANK_W)
    ) u_bankMap (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_bankWe),
        .i_idx     (w_bankIdx),
        .i_wdata   (w_bankWdata),
        .o_rdata   (w_bankRdata),
        .i_memAddr (bus.A),
        .o_axiAddr (w_memAddr)
    );

    // UART port decode: only the direction each register supports is forwarded.
    always_comb begin
        w_uartHit  = 1'b0;
        w_uartAddr = '0;
        if (bus.IO && bus.RD && (w_port == UART_PORT_RX)) begin
            w_uartHit  = 1'b1;
            w_uartAddr = AXI_ADDR32_UART_RX;
        end else if (bus.IO && bus.RD && (w_port == UART_PORT_STAT)) begin
            w_uartHit  = 1'b1;
            w_uartAddr = AXI_ADDR32_UART_STAT;
        end else if (bus.IO && bus.WR && (w_port == UART_PORT_TX)) begin
            w_uartHit  = 1'b1;
            w_uartAddr = AXI_ADDR32_UART_TX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Local accesses and decode errors finish straight away; everything else
    // goes through the AXI handshake. DONE waits for the CPU to drop RD/WR.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_legal) w_nextState = w_goReq ? REQ : DONE;
            REQ:  if (bus.req_ready) w_nextState = RESP;
            RESP: if (bus.resp_valid || (r_cnt == TIMEOUT_MAX)) w_nextState = DONE;
            DONE: if (!bus.RD && !bus.WR) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so they stay stable while
    // req_valid waits for req_ready. A response on the timeout cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reqAddr   <= '0;
            r_reqWdata  <= '0;
            r_reqWstrb  <= '0;
            r_reqIsRead <= 1'b0;
            r_lane      <= '0;
            r_cpuRdata  <= 8'hFF;
            r_errFlag   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        if (w_goReq) begin
                            r_reqAddr   <= bus.MEM ? w_memAddr : w_uartAddr;
                            r_reqWdata  <= {4{bus.D}};
                            r_reqWstrb  <= bus.WR ? laneStrobe(w_lane) : 4'b0000;
                            r_reqIsRead <= bus.RD;
                            r_lane      <= w_lane;
                        end else if (w_bankHit) begin
                            if (bus.RD) r_cpuRdata <= 8'(w_bankRdata);
                        end else begin
                            r_errFlag  <= 1'b1;
                            r_cpuRdata <= 8'hFF;
                        end
                    end
                end
                REQ: r_cnt <= '0;
                RESP: begin
                    if (r_cnt != TIMEOUT_MAX) r_cnt <= r_cnt + 8'd1;
                    if (bus.resp_valid) begin
                        if (bus.resp_err) begin
                            r_errFlag  <= 1'b1;
                            r_cpuRdata <= 8'hFF;
                        end else if (r_reqIsRead) begin
                            r_cpuRdata <= laneByte(bus.resp_rdata, r_lane);
                        end
                    end else if (r_cnt == TIMEOUT_MAX) begin
                        r_errFlag  <= 1'b1;
                        r_cpuRdata <= 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_ready   = (r_state == DONE);
    assign bus.req_valid   = (r_state == REQ);
    assign bus.cpu_rdata   = r_cpuRdata;
    assign bus.req_addr    = r_reqAddr;
    assign bus.req_wdata   = r_reqWdata;
    assign bus.req_wstrb   = r_reqWstrb;
    assign bus.req_is_read = r_reqIsRead;
    assign bus.err_flag    = r_errFlag;

endmodule

// File: tb/tb_bus_cycle_bridge.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_bridge
// Directed bench for bus_cycle_bridge: memory and IO cycles, bank remapping,
// request stalls, response errors, timeout and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bus_cycle_bridge;
    import bus_bridge_pkg::*;

    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;
    int   hsCount     = 0;

    bus_cycle_bridge_if #(.ADDR_WIDTH(20)) bus ();

    bus_cycle_bridge #(
        .ADDR_WIDTH     (20),
        .NUM_WINDOWS    (4),
        .BANK_W         (8),
        .BANK_IO_BASE   (8'h90),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count accepted requests as the AXI side would see them.
    always @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) hsCount <= hsCount + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBus(input logic io, input logic mem, input logic rd, input logic wr,
                          input logic [19:0] a, input logic [7:0] d);
        bus.IO  = io;
        bus.MEM = mem;
        bus.RD  = rd;
        bus.WR  = wr;
        bus.A   = a;
        bus.D   = d;
    endtask

    task automatic doReset();
        rst = 1'b1;
        setBus(0, 0, 0, 0, 20'h0, 8'h0);
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        assertCount++;
        if ({bus.cpu_ready, bus.req_valid, bus.req_is_read, bus.err_flag} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {bus.cpu_ready, bus.req_valid, bus.req_is_read, bus.err_flag});
        end
        assertCount++;
        if ({bus.req_addr, bus.req_wdata, bus.req_wstrb} !== 68'h0) begin
            failCount++;
            $display("[TB] FAIL reset_req_fields: got %h %h %h expected 0 0 0",
                     bus.req_addr, bus.req_wdata, bus.req_wstrb);
        end
        assertCount++;
        if (bus.cpu_rdata !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL reset_cpu_rdata: got %h expected ff", bus.cpu_rdata);
        end
    endtask

    task automatic test_mem_read();
        int hsBefore;
        setBus(0, 1, 1, 0, 20'h4_1235, 8'h00);
        tick();
        assertCount++;
        if ({bus.req_valid, bus.req_is_read, bus.req_wstrb, bus.cpu_ready} !== 7'b1100000) begin
            failCount++;
            $display("[TB] FAIL memrd_req_ctrl: got %b expected 1100000",
                     {bus.req_valid, bus.req_is_read, bus.req_wstrb, bus.cpu_ready});
        end
        assertCount++;
        if (bus.req_addr !== (AXI_ADDR32_DRAM_BASE | 32'h0004_1235)) begin
            failCount++;
            $display("[TB] FAIL memrd_req_addr: got %h expected %h", bus.req_addr,
                     AXI_ADDR32_DRAM_BASE | 32'h0004_1235);
        end
        hsBefore = hsCount;
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        assertCount++;
        if ({bus.req_valid, 32'(hsCount - hsBefore)} !== {1'b0, 32'd1}) begin
            failCount++;
            $display("[TB] FAIL memrd_handshake: got valid=%b hs=%0d expected valid=0 hs=1",
                     bus.req_valid, hsCount - hsBefore);
        end
        tick();
        tick();
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'hAABBCCDD;
        bus.resp_err   = 1'b0;
        assertCount++;
        if (bus.cpu_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL memrd_wait_state: got %b expected 0", bus.cpu_ready);
        end
        tick();
        bus.resp_valid = 1'b0;
        assertCount++;
        if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 8'hCC}) begin
            failCount++;
            $display("[TB] FAIL memrd_data: got ready=%b data=%h expected ready=1 data=cc",
                     bus.cpu_ready, bus.cpu_rdata);
        end
        tick();
        tick();
        assertCount++;
        if (bus.cpu_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL memrd_hold_ready: got %b expected 1", bus.cpu_ready);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        assertCount++;
        if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b0, 8'hCC}) begin
            failCount++;
            $display("[TB] FAIL memrd_release: got ready=%b data=%h expected ready=0 data=cc",
                     bus.cpu_ready, bus.cpu_rdata);
        end
    endtask

    task automatic test_bank_mem_write();
        setBus(1, 0, 0, 1, 20'h0_0092, 8'h3C);
        tick();
        assertCount++;
        if ({bus.cpu_ready, bus.req_valid} !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL bankwr_local: got %b expected 10", {bus.cpu_ready, bus.req_valid});
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        setBus(1, 0, 1, 0, 20'h0_0092, 8'h00);
        tick();
        assertCount++;
        if (bus.cpu_rdata !== 8'h3C) begin
            failCount++;
            $display("[TB] FAIL bankrd_value: got %h expected 3c", bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        setBus(0, 1, 0, 1, 20'h8_0002, 8'h5A);
        tick();
        assertCount++;
        if (bus.req_addr !== (AXI_ADDR32_DRAM_BASE | 32'h00F0_0002)) begin
            failCount++;
            $display("[TB] FAIL memwr_addr: got %h expected %h", bus.req_addr,
                     AXI_ADDR32_DRAM_BASE | 32'h00F0_0002);
        end
        assertCount++;
        if ({bus.req_valid, bus.req_is_read, bus.req_wstrb, bus.req_wdata} !== {2'b10, 4'b0100, 32'h5A5A5A5A}) begin
            failCount++;
            $display("[TB] FAIL memwr_lanes: got v/r=%b strb=%b data=%h expected 10 0100 5a5a5a5a",
                     {bus.req_valid, bus.req_is_read}, bus.req_wstrb, bus.req_wdata);
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'hDEADBEEF;
        tick();
        bus.resp_valid = 1'b0;
        assertCount++;
        if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 8'h3C}) begin
            failCount++;
            $display("[TB] FAIL memwr_done: got ready=%b data=%h expected ready=1 data=3c",
                     bus.cpu_ready, bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_req_stall();
        int hsBefore;
        setBus(0, 1, 1, 0, 20'h0_0010, 8'h00);
        tick();
        hsBefore = hsCount;
        for (int i = 0; i < 10; i++) begin
            assertCount++;
            if ({bus.req_valid, bus.req_addr, bus.req_wstrb, bus.req_is_read} !==
                {1'b1, AXI_ADDR32_DRAM_BASE | 32'h0000_0010, 4'b0000, 1'b1}) begin
                failCount++;
                $display("[TB] FAIL stall_stable[%0d]: got v=%b addr=%h strb=%b rd=%b expected 1 %h 0000 1",
                         i, bus.req_valid, bus.req_addr, bus.req_wstrb, bus.req_is_read,
                         AXI_ADDR32_DRAM_BASE | 32'h0000_0010);
            end
            if (i != 9) tick();
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        tick();
        tick();
        assertCount++;
        if ({bus.req_valid, 32'(hsCount - hsBefore)} !== {1'b0, 32'd1}) begin
            failCount++;
            $display("[TB] FAIL stall_one_handshake: got valid=%b hs=%0d expected valid=0 hs=1",
                     bus.req_valid, hsCount - hsBefore);
        end
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h11223344;
        tick();
        bus.resp_valid = 1'b0;
        assertCount++;
        if (bus.cpu_rdata !== 8'h44) begin
            failCount++;
            $display("[TB] FAIL stall_lane0_data: got %h expected 44", bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_io_error();
        assertCount++;
        if (bus.err_flag !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ioerr_pre_flag: got %b expected 0", bus.err_flag);
        end
        setBus(1, 0, 1, 0, 20'h0_0055, 8'h00);
        tick();
        assertCount++;
        if ({bus.cpu_ready, bus.req_valid, bus.err_flag, bus.cpu_rdata} !== {3'b101, 8'hFF}) begin
            failCount++;
            $display("[TB] FAIL ioerr_result: got rdy/v/err=%b data=%h expected 101 ff",
                     {bus.cpu_ready, bus.req_valid, bus.err_flag}, bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_illegal_strobes();
        setBus(1, 1, 1, 0, 20'h0_0092, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            assertCount++;
            if ({bus.cpu_ready, bus.req_valid} !== 2'b00) begin
                failCount++;
                $display("[TB] FAIL illegal_io_mem[%0d]: got %b expected 00", i,
                         {bus.cpu_ready, bus.req_valid});
            end
        end
        setBus(0, 1, 1, 1, 20'h0_0010, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            assertCount++;
            if ({bus.cpu_ready, bus.req_valid} !== 2'b00) begin
                failCount++;
                $display("[TB] FAIL illegal_rd_wr[%0d]: got %b expected 00", i,
                         {bus.cpu_ready, bus.req_valid});
            end
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_reset_in_resp();
        setBus(1, 0, 0, 1, 20'h0_0091, 8'h77);
        tick();
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        setBus(0, 1, 1, 0, 20'h4_0000, 8'h00);
        tick();
        assertCount++;
        if (bus.req_addr !== (AXI_ADDR32_DRAM_BASE | 32'h01DC_0000)) begin
            failCount++;
            $display("[TB] FAIL remap_addr: got %h expected %h", bus.req_addr,
                     AXI_ADDR32_DRAM_BASE | 32'h01DC_0000);
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        assertCount++;
        if ({bus.cpu_ready, bus.req_valid, bus.req_is_read, bus.err_flag, bus.cpu_rdata} !== {4'b0000, 8'hFF}) begin
            failCount++;
            $display("[TB] FAIL async_reset_flags: got %b data=%h expected 0000 ff",
                     {bus.cpu_ready, bus.req_valid, bus.req_is_read, bus.err_flag}, bus.cpu_rdata);
        end
        assertCount++;
        if ({bus.req_addr, bus.req_wdata, bus.req_wstrb} !== 68'h0) begin
            failCount++;
            $display("[TB] FAIL async_reset_fields: got %h %h %h expected 0 0 0",
                     bus.req_addr, bus.req_wdata, bus.req_wstrb);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        setBus(0, 1, 1, 0, 20'h4_0000, 8'h00);
        tick();
        assertCount++;
        if (bus.req_addr !== (AXI_ADDR32_DRAM_BASE | 32'h0004_0000)) begin
            failCount++;
            $display("[TB] FAIL bank_identity_after_reset: got %h expected %h", bus.req_addr,
                     AXI_ADDR32_DRAM_BASE | 32'h0004_0000);
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h0;
        tick();
        bus.resp_valid = 1'b0;
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_timeout();
        int  n;
        logic got;
        assertCount++;
        if (bus.err_flag !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_pre_flag: got %b expected 0", bus.err_flag);
        end
        setBus(0, 1, 1, 0, 20'h0_0004, 8'h00);
        bus.req_ready = 1'b1;
        tick();
        tick();
        bus.req_ready = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 300 && !got) begin
            tick();
            n++;
            if (bus.cpu_ready === 1'b1) got = 1'b1;
        end
        assertCount++;
        if ({got, 32'(n)} !== {1'b1, 32'(TIMEOUT + 1)}) begin
            failCount++;
            $display("[TB] FAIL timeout_cycles: got ready=%b after %0d cycles expected ready=1 after %0d",
                     got, n, TIMEOUT + 1);
        end
        assertCount++;
        if ({bus.err_flag, bus.cpu_rdata} !== {1'b1, 8'hFF}) begin
            failCount++;
            $display("[TB] FAIL timeout_error: got err=%b data=%h expected err=1 data=ff",
                     bus.err_flag, bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h5555_5555;
        tick();
        bus.resp_valid = 1'b0;
        tick();
        assertCount++;
        if ({bus.cpu_ready, bus.req_valid, bus.cpu_rdata} !== {2'b00, 8'hFF}) begin
            failCount++;
            $display("[TB] FAIL late_resp_ignored: got rdy/v=%b data=%h expected 00 ff",
                     {bus.cpu_ready, bus.req_valid}, bus.cpu_rdata);
        end
    endtask

    task automatic test_resp_err();
        doReset();
        setBus(0, 1, 1, 0, 20'h0_0003, 8'h00);
        bus.req_ready = 1'b1;
        tick();
        tick();
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        bus.resp_rdata = 32'h12345678;
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        assertCount++;
        if ({bus.cpu_ready, bus.err_flag, bus.cpu_rdata} !== {2'b11, 8'hFF}) begin
            failCount++;
            $display("[TB] FAIL resp_err: got rdy/err=%b data=%h expected 11 ff",
                     {bus.cpu_ready, bus.err_flag}, bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    task automatic test_back_to_back();
        setBus(0, 1, 1, 0, 20'h0_0003, 8'h00);
        bus.req_ready = 1'b1;
        tick();
        tick();
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h12345678;
        tick();
        bus.resp_valid = 1'b0;
        assertCount++;
        if (bus.cpu_rdata !== 8'h12) begin
            failCount++;
            $display("[TB] FAIL b2b_lane3_data: got %h expected 12", bus.cpu_rdata);
        end
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
        setBus(0, 1, 0, 1, 20'h0_0001, 8'hA5);
        tick();
        assertCount++;
        if ({bus.req_valid, bus.req_wstrb, bus.req_wdata, bus.req_addr} !==
            {1'b1, 4'b0010, 32'hA5A5A5A5, AXI_ADDR32_DRAM_BASE | 32'h0000_0001}) begin
            failCount++;
            $display("[TB] FAIL b2b_write_req: got v=%b strb=%b data=%h addr=%h expected 1 0010 a5a5a5a5 %h",
                     bus.req_valid, bus.req_wstrb, bus.req_wdata, bus.req_addr,
                     AXI_ADDR32_DRAM_BASE | 32'h0000_0001);
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        tick();
    endtask

    initial begin
        setBus(0, 0, 0, 0, 20'h0, 8'h00);
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        $display("[TB] starting bus_cycle_bridge directed tests");
        test_reset();
        test_mem_read();
        test_bank_mem_write();
        test_req_stall();
        test_io_error();
        test_illegal_strobes();
        test_reset_in_resp();
        test_timeout();
        test_resp_err();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bus_cycle_bridge.md
Name: bus_cycle_bridge

Overview:
- Sequencing bridge between the 8-bit CPU bus strobes (IO/MEM/RD/WR, A, D) and the 32-bit AXI request/response port. It replaces the purely combinational address conversion.
- Adds banked memory windows, true byte-lane steering, a CPU wait handshake (cpu_ready), a response timeout and error reporting.
- Sits between the CPU pin interface and the AXI master shim.

Parameters:
- ADDR_WIDTH, 20: CPU address width.
- NUM_WINDOWS, 4: number of banked memory windows (power of two, ≥2). The window index is A[ADDR_WIDTH-1 -: log2(NUM_WINDOWS)]; OFF_W = ADDR_WIDTH - log2(NUM_WINDOWS) is the derived window offset width.
- BANK_W, 8: bank register width. The constraint BANK_W + OFF_W ≤ 28 must hold.
- BANK_IO_BASE, 8'h90: IO port of bank register 0. Register i is at BANK_IO_BASE+i.
- TIMEOUT_CYCLES, 255: maximum cycles spent in RESP before an error is forced (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- IO, MEM, RD, WR  in  1 each  CPU cycle strobes, active-high, synchronous to clk
- A  in  ADDR_WIDTH  CPU address
- D  in  8  CPU write data
- cpu_ready  out  1  1 = cycle complete; CPU wait state while 0
- cpu_rdata  out  8  read byte; valid while cpu_ready=1 on a read
- req_valid  out  1  AXI request valid
- req_ready  in  1  AXI request accepted
- req_addr  out  32  byte address
- req_wdata  out  32  write data
- req_wstrb  out  4  byte strobes; 0 on reads
- req_is_read  out  1  1 = read request
- resp_valid  in  1  AXI response valid (one-cycle pulse)
- resp_rdata  in  32  read data
- resp_err  in  1  slave error, qualified by resp_valid
- err_flag  out  1  sticky error; cleared by reset only

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE.
  - cpu_ready, req_valid, req_is_read, err_flag = 0.
  - req_addr, req_wdata, req_wstrb = 0; cpu_rdata = 8'hFF.
  - bank[i] = i (identity map).
  - Reset asserted mid-cycle abandons any outstanding request with no handshake completion.
- A legal cycle is exactly one of {IO,MEM} high and exactly one of {RD,WR} high.
  - All other strobe combinations in IDLE are ignored; no state change.
- IDLE, on a legal cycle: latch A, D, the strobes and the byte lane L = A[1:0], then decode in the same cycle.
  - MEM access: req_addr = AXI_ADDR32_DRAM_BASE | ({bank[win], A[OFF_W-1:0]} zero-extended).
  - IO write to a bank port with i < NUM_WINDOWS: bank[i] <= D[BANK_W-1:0] (zero-extended if BANK_W > 8). Go to DONE; no AXI request.
  - IO read of a bank port: cpu_rdata = bank[i] (low 8 bits). Go to DONE.
  - IO port 0 read → AXI_ADDR32_UART_RX.
  - IO port 2 read → AXI_ADDR32_UART_STAT.
  - IO port 1 write → AXI_ADDR32_UART_TX.
  - Any other IO access: err_flag <= 1, cpu_rdata = 8'hFF, go to DONE.
  - Otherwise go to REQ.
- REQ:
  - req_valid = 1, with all req_* outputs stable until req_ready is sampled high.
  - Handshake completes on the first clk edge with req_valid & req_ready; move to RESP.
  - req_valid drops in the following cycle.
- Byte-lane rules:
  - Writes: req_wstrb = 4'b0001 << L; req_wdata = {4{D}}.
  - Reads: req_wstrb = 0.
  - UART TX is treated the same way, with L taken from its AXI address (lane 0).
- RESP:
  - An 8-bit counter (clamped at TIMEOUT_CYCLES) starts at 0 on entry and increments each cycle.
  - On resp_valid: cpu_rdata = resp_rdata[8L+7 -: 8] for reads. If resp_err, also set err_flag and force cpu_rdata = 8'hFF. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without resp_valid: err_flag <= 1, cpu_rdata = 8'hFF, go to DONE.
  - A late resp_valid arriving in any state other than RESP is ignored.
  - resp_valid on the timeout cycle takes priority over the timeout.
- DONE:
  - cpu_ready = 1 and cpu_rdata is held.
  - Stay until RD=0 and WR=0 (the end of the CPU cycle), then go to IDLE with cpu_ready = 0 in the next cycle.
- Latency:
  - Internal bank access: cpu_ready rises 1 cycle after the strobe is sampled.
  - AXI access: cpu_ready rises 1 cycle after resp_valid.
- Back-to-back cycles: a new cycle is only accepted in IDLE, so at least one idle cycle follows each DONE.

Decomposition:
- Package bus_bridge_pkg holds:
  - state_t enum (IDLE, REQ, RESP, DONE);
  - the AXI_ADDR32_* constants, reused from the existing address map include;
  - UART port numbers;
  - a lane-select helper function.
- Sub-module bank_window_map:
  - owns the bank register array and its write port;
  - provides combinational translation of a MEM address to a 32-bit AXI address.

Test Plan:
- Reset, then MEM read A=20'h4_1235, resp_rdata=32'hAABBCCDD after 3 cycles → req_addr=DRAM_BASE|{8'h01,18'h01235}, wstrb=0, cpu_rdata=8'hCC, cpu_ready high until RD drops.
- IO write port 8'h92, D=8'h3C; then MEM write A=20'h8_0002, D=8'h5A → bank[2]=8'h3C, req_addr=DRAM_BASE|{8'h3C,18'h00002}, wstrb=4'b0100, wdata=32'h5A5A5A5A.
- req_ready held low for 10 cycles → req_valid and req_* stable for all 10 cycles, exactly one handshake.
- No resp_valid after the request → after TIMEOUT_CYCLES: err_flag=1, cpu_rdata=8'hFF, cpu_ready=1; a later resp_valid in IDLE is ignored.
- IO read of port 8'h55 → no req_valid, err_flag=1, cpu_rdata=8'hFF; illegal strobes IO=MEM=1 leave the FSM in IDLE.
- Assert rst while in RESP → immediate IDLE, all outputs at reset values, bank registers back to identity.
